// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: decode-side read/busy ports and writeback-side write port.
// The core drives the master side; the register file takes the slave side.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            clear_req;
  logic [AW-1:0]   read_1;
  logic [AW-1:0]   read_2;
  logic [XLEN-1:0] data_1;
  logic [XLEN-1:0] data_2;
  logic [AW-1:0]   write;
  logic [XLEN-1:0] write_data;
  logic            regWrite;
  logic            busy_set;
  logic [AW-1:0]   busy_rd;
  logic            busy_1;
  logic            busy_2;
  logic            ready;

  modport master (
    output clear_req, read_1, read_2, write, write_data, regWrite, busy_set, busy_rd,
    input  data_1, data_2, busy_1, busy_2, ready
  );

  modport slave (
    input  clear_req, read_1, read_2, write, write_data, regWrite, busy_set, busy_rd,
    output data_1, data_2, busy_1, busy_2, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with x0 hardwired to zero, optional write bypass, a per-register
// busy scoreboard and a one-register-per-cycle clear sweep in place of a wide reset.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [XLEN-1:0] arr_wdata;
  logic            run;

  assign run       = (state_q == StRun);
  assign bus.ready = run;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    arr_we    = 1'b0;
    arr_addr  = bus.write;
    arr_wdata = bus.write_data;
    unique case (state_q)
      StClear: begin
        arr_we    = 1'b1;
        arr_addr  = clr_idx_q;
        arr_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        busy_d    = '0;
        if (clr_idx_q == AW'(NREG - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.clear_req) begin
          // Any write in this cycle is dropped; the sweep will zero everything anyway.
          state_d   = StClear;
          clr_idx_d = '0;
          busy_d    = '0;
        end else begin
          arr_we = bus.regWrite && (bus.write != '0);
          if (arr_we) begin
            busy_d[bus.write] = 1'b0;
          end
          // Set after clear: a newly issued producer outranks the retiring one.
          if (bus.busy_set && (bus.busy_rd != '0)) begin
            busy_d[bus.busy_rd] = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StClear;
        clr_idx_d = '0;
        busy_d    = '0;
      end
    endcase
    if (rst) begin
      arr_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs_q[arr_addr] <= arr_wdata;
    end
  end

  // Outputs forced to zero until the first sweep has defined the array.
  always_comb begin
    bus.data_1 = '0;
    bus.data_2 = '0;
    bus.busy_1 = 1'b0;
    bus.busy_2 = 1'b0;
    if (run) begin
      bus.busy_1 = busy_q[bus.read_1];
      bus.busy_2 = busy_q[bus.read_2];
      if (bus.read_1 != '0) begin
        bus.data_1 = (BYPASS && bus.regWrite && (bus.write == bus.read_1)) ?
                     bus.write_data : regs_q[bus.read_1];
      end
      if (bus.read_2 != '0) begin
        bus.data_2 = (BYPASS && bus.regWrite && (bus.write == bus.read_2)) ?
                     bus.write_data : regs_q[bus.read_2];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and 16x64 instances share clk/rst.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREG(32)) bus0 ();
  regfile_sb_if #(.XLEN(32), .NREG(32)) bus1 ();
  regfile_sb_if #(.XLEN(64), .NREG(16)) bus2 ();

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus0.clear_req = 0; bus0.read_1 = 0; bus0.read_2 = 0; bus0.write = 0;
    bus0.write_data = 0; bus0.regWrite = 0; bus0.busy_set = 0; bus0.busy_rd = 0;
    bus1.clear_req = 0; bus1.read_1 = 0; bus1.read_2 = 0; bus1.write = 0;
    bus1.write_data = 0; bus1.regWrite = 0; bus1.busy_set = 0; bus1.busy_rd = 0;
    bus2.clear_req = 0; bus2.read_1 = 0; bus2.read_2 = 0; bus2.write = 0;
    bus2.write_data = 0; bus2.regWrite = 0; bus2.busy_set = 0; bus2.busy_rd = 0;

    // 1. Reset and clear sweep length
    step();
    rst = 1'b0;
    bus0.read_1 = 5'd3;
    #1;
    chk("rst_ready", {63'd0, bus0.ready}, 64'd0);
    chk("rst_busy1", {63'd0, bus0.busy_1}, 64'd0);
    for (int e = 1; e <= 32; e++) begin
      step();
      chk("sweep_ready", {63'd0, bus0.ready}, (e == 32) ? 64'd1 : 64'd0);
      chk("sweep_data1", {32'd0, bus0.data_1}, 64'd0);
      chk("sweep16_ready", {63'd0, bus2.ready}, (e >= 16) ? 64'd1 : 64'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 31) chk("restart_ready31", {63'd0, bus0.ready}, 64'd0);
      if (e == 32) chk("restart_ready32", {63'd0, bus0.ready}, 64'd1);
    end

    // 2. Bypass vs no bypass
    bus0.regWrite = 1; bus0.write = 5'd5; bus0.write_data = 32'hDEADBEEF; bus0.read_1 = 5'd5;
    bus1.regWrite = 1; bus1.write = 5'd5; bus1.write_data = 32'hDEADBEEF; bus1.read_1 = 5'd5;
    #1;
    chk("bypass_on", {32'd0, bus0.data_1}, 64'hDEADBEEF);
    chk("bypass_off_old", {32'd0, bus1.data_1}, 64'd0);
    step();
    bus0.regWrite = 0;
    bus1.regWrite = 0;
    #1;
    chk("bypass_off_after", {32'd0, bus1.data_1}, 64'hDEADBEEF);
    chk("bypass_on_after", {32'd0, bus0.data_1}, 64'hDEADBEEF);

    // 3. x0 is hardwired
    bus0.regWrite = 1; bus0.write = 5'd0; bus0.write_data = 32'h1234;
    bus0.read_1 = 5'd0; bus0.busy_set = 1; bus0.busy_rd = 5'd0;
    #1;
    chk("x0_bypass", {32'd0, bus0.data_1}, 64'd0);
    step();
    bus0.regWrite = 0; bus0.busy_set = 0;
    #1;
    chk("x0_data", {32'd0, bus0.data_1}, 64'd0);
    chk("x0_busy", {63'd0, bus0.busy_1}, 64'd0);

    // 4. Scoreboard set / clear / set-wins
    bus0.busy_set = 1; bus0.busy_rd = 5'd7; bus0.read_1 = 5'd7; bus0.read_2 = 5'd7;
    #1;
    chk("busy_not_bypassed", {63'd0, bus0.busy_1}, 64'd0);
    step();
    bus0.busy_set = 0;
    #1;
    chk("busy_set_p1", {63'd0, bus0.busy_1}, 64'd1);
    chk("busy_set_p2", {63'd0, bus0.busy_2}, 64'd1);
    bus0.regWrite = 1; bus0.write = 5'd7; bus0.write_data = 32'h77;
    step();
    bus0.regWrite = 0;
    #1;
    chk("busy_cleared", {63'd0, bus0.busy_1}, 64'd0);
    bus0.regWrite = 1; bus0.busy_set = 1;
    step();
    bus0.regWrite = 0; bus0.busy_set = 0;
    #1;
    chk("busy_set_wins", {63'd0, bus0.busy_1}, 64'd1);

    // 5. Load then clear
    bus0.regWrite = 1;
    for (int i = 1; i <= 31; i++) begin
      bus0.write = 5'(i);
      bus0.write_data = 32'(i);
      step();
    end
    bus0.regWrite = 0;
    bus0.read_1 = 5'd31; bus0.read_2 = 5'd17;
    #1;
    chk("load_x31", {32'd0, bus0.data_1}, 64'd31);
    chk("load_x17", {32'd0, bus0.data_2}, 64'd17);
    bus0.busy_set = 1; bus0.busy_rd = 5'd3;
    step();
    bus0.busy_set = 0; bus0.read_1 = 5'd3;
    #1;
    chk("pre_clear_busy3", {63'd0, bus0.busy_1}, 64'd1);
    bus0.clear_req = 1;
    step();
    bus0.clear_req = 0;
    #1;
    chk("clear_ready0", {63'd0, bus0.ready}, 64'd0);
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 31) chk("clear_ready31", {63'd0, bus0.ready}, 64'd0);
      if (e == 32) chk("clear_ready32", {63'd0, bus0.ready}, 64'd1);
      if (e == 10) bus0.clear_req = 1;
      if (e == 11) bus0.clear_req = 0;
      if (e == 12) begin
        bus0.regWrite = 1; bus0.write = 5'd2; bus0.write_data = 32'hAA;
      end
      if (e == 13) bus0.regWrite = 0;
    end
    for (int i = 0; i < 32; i++) begin
      bus0.read_1 = 5'(i);
      bus0.read_2 = 5'(31 - i);
      #1;
      chk("post_clear_d1", {32'd0, bus0.data_1}, 64'd0);
      chk("post_clear_d2", {32'd0, bus0.data_2}, 64'd0);
      chk("post_clear_busy", {63'd0, bus0.busy_1}, 64'd0);
    end

    // 6. 16 x 64 instance
    bus2.regWrite = 1; bus2.write = 4'd15; bus2.write_data = 64'hFFFF_0000_1234_5678;
    step();
    bus2.regWrite = 0; bus2.read_1 = 4'd15; bus2.read_2 = 4'd15;
    #1;
    chk("w64_p1", bus2.data_1, 64'hFFFF_0000_1234_5678);
    chk("w64_p2", bus2.data_2, 64'hFFFF_0000_1234_5678);
    bus2.read_2 = 4'd0;
    #1;
    chk("w64_x0", bus2.data_2, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
